// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage.
// Holds the datapath widths, the ALU operation encoding and the operand-entry
// layout used by the output and skid slots.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // tag1/tag2 hold the source register index still being tracked, or 0
    // when the operand is final (register 0 or an immediate).
    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [REG_AW-1:0] tag1;
        logic [REG_AW-1:0] tag2;
        alu_op_e           op;
        logic [REG_AW-1:0] rd;
    } operand_entry_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bundle of the operand stage's handshake, register-file and bypass signals.
// Ports: upstream instruction (inValid/inReady/inOp/inRs1/inRs2/inRd/inImm/
// inUseImm), register-file read (rfRaddr1/2, rfRdata1/2), execute and
// writeback bypass buses, and the ALU-facing output (outValid/outReady/
// aluIn1/aluIn2/aluOp/outRd).
// master: the surrounding pipeline; slave: the operand stage itself.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic              inValid;
    logic              inReady;
    logic              inOp;
    logic [REG_AW-1:0] inRs1;
    logic [REG_AW-1:0] inRs2;
    logic [REG_AW-1:0] inRd;
    logic [DATA_W-1:0] inImm;
    logic              inUseImm;

    logic [REG_AW-1:0] rfRaddr1;
    logic [REG_AW-1:0] rfRaddr2;
    logic [DATA_W-1:0] rfRdata1;
    logic [DATA_W-1:0] rfRdata2;

    logic              exFwdValid;
    logic [REG_AW-1:0] exFwdRd;
    logic [DATA_W-1:0] exFwdData;
    logic              wbFwdValid;
    logic [REG_AW-1:0] wbFwdRd;
    logic [DATA_W-1:0] wbFwdData;

    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] aluIn1;
    logic [DATA_W-1:0] aluIn2;
    logic              aluOp;
    logic [REG_AW-1:0] outRd;

    modport master (
        output inValid, inOp, inRs1, inRs2, inRd, inImm, inUseImm,
        output rfRdata1, rfRdata2,
        output exFwdValid, exFwdRd, exFwdData,
        output wbFwdValid, wbFwdRd, wbFwdData,
        output outReady,
        input  inReady, rfRaddr1, rfRaddr2,
        input  outValid, aluIn1, aluIn2, aluOp, outRd
    );

    modport slave (
        input  inValid, inOp, inRs1, inRs2, inRd, inImm, inUseImm,
        input  rfRdata1, rfRdata2,
        input  exFwdValid, exFwdRd, exFwdData,
        input  wbFwdValid, wbFwdRd, wbFwdData,
        input  outReady,
        output inReady, rfRaddr1, rfRaddr2,
        output outValid, aluIn1, aluIn2, aluOp, outRd
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Priority select for one operand.
// Ports: tag (source index, 0 = final), cur_data (value used when nothing
// matches), ex/wb bypass buses, data (resolved operand).
// A zero tag never matches a bus, so register 0 is never forwarded.
module operand_fwd_mux
    import alu_pkg::*;
(
    input  logic [REG_AW-1:0] tag,
    input  logic [DATA_W-1:0] cur_data,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = cur_data;
        if (tag != '0) begin
            if (ex_valid && ex_rd == tag) begin
                data = ex_data;
            end else if (wb_valid && wb_rd == tag) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand issue stage in front of the execute ALU.
// Ports: clk, rst_n (synchronous, active low), bus (slave side of
// alu_operand_stage_if carrying the upstream, register-file, bypass and
// ALU-facing signals).
// Two slots: O drives the ALU, S is a skid entry that lets inReady be a flop.
// Both slots keep snooping the bypass buses while they wait.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_stage_if.slave   bus
);

    operand_entry_t o_q, s_q, o_d, s_d;
    operand_entry_t cap, o_snp, s_snp;
    logic           o_valid_q, s_valid_q, in_ready_q;
    logic           o_valid_d, s_valid_d;
    logic           accept, drain;

    logic [REG_AW-1:0] cap_tag2;
    logic [DATA_W-1:0] cap_base1, cap_base2;
    logic [DATA_W-1:0] cap_data1, cap_data2;
    logic [DATA_W-1:0] o_snp1, o_snp2, s_snp1, s_snp2;

    assign bus.rfRaddr1 = bus.inRs1;
    assign bus.rfRaddr2 = bus.inRs2;

    assign accept = bus.inValid && in_ready_q;
    assign drain  = o_valid_q && bus.outReady;

    // Fallback values when no bypass matches: zero for r0, the immediate for
    // operand 2 when selected, otherwise the register file.
    assign cap_tag2  = bus.inUseImm ? '0 : bus.inRs2;
    assign cap_base1 = (bus.inRs1 == '0) ? '0 : bus.rfRdata1;
    assign cap_base2 = bus.inUseImm ? bus.inImm
                     : ((bus.inRs2 == '0) ? '0 : bus.rfRdata2);

    operand_fwd_mux u_cap1 (
        .tag(bus.inRs1), .cur_data(cap_base1),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(cap_data1)
    );
    operand_fwd_mux u_cap2 (
        .tag(cap_tag2), .cur_data(cap_base2),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(cap_data2)
    );
    operand_fwd_mux u_o_snp1 (
        .tag(o_q.tag1), .cur_data(o_q.data1),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(o_snp1)
    );
    operand_fwd_mux u_o_snp2 (
        .tag(o_q.tag2), .cur_data(o_q.data2),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(o_snp2)
    );
    operand_fwd_mux u_s_snp1 (
        .tag(s_q.tag1), .cur_data(s_q.data1),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(s_snp1)
    );
    operand_fwd_mux u_s_snp2 (
        .tag(s_q.tag2), .cur_data(s_q.data2),
        .ex_valid(bus.exFwdValid), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .wb_valid(bus.wbFwdValid), .wb_rd(bus.wbFwdRd), .wb_data(bus.wbFwdData),
        .data(s_snp2)
    );

    always_comb begin
        cap       = '0;
        cap.data1 = cap_data1;
        cap.data2 = cap_data2;
        cap.tag1  = bus.inRs1;
        cap.tag2  = cap_tag2;
        cap.op    = alu_op_e'(bus.inOp);
        cap.rd    = bus.inRd;

        o_snp       = o_q;
        o_snp.data1 = o_snp1;
        o_snp.data2 = o_snp2;
        s_snp       = s_q;
        s_snp.data1 = s_snp1;
        s_snp.data2 = s_snp2;
    end

    // S valid implies inReady is low, so accept never coincides with an S->O move.
    always_comb begin
        o_d       = o_snp;
        s_d       = s_snp;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        if (drain && s_valid_q) begin
            o_d       = s_snp;
            s_valid_d = 1'b0;
        end else if (accept && (!o_valid_q || drain)) begin
            o_d       = cap;
            o_valid_d = 1'b1;
        end else if (accept) begin
            s_d       = cap;
            s_valid_d = 1'b1;
        end else if (drain) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q        <= '0;
            s_q        <= '0;
            o_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            o_q        <= o_d;
            s_q        <= s_d;
            o_valid_q  <= o_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= !s_valid_d;
        end
    end

    assign bus.inReady  = in_ready_q;
    assign bus.outValid = o_valid_q;
    assign bus.aluIn1   = o_q.data1;
    assign bus.aluIn2   = o_q.data2;
    assign bus.aluOp    = o_q.op;
    assign bus.outRd    = o_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// randomized traffic, all compared against an in-order queue model.
module tb_alu_operand_stage;

    logic clk;
    logic rst_n;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];

    always_comb begin
        bus.rfRdata1 = rf_mem[bus.rfRaddr1];
        bus.rfRdata2 = rf_mem[bus.rfRaddr2];
    end

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic        op;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // A nonzero register name picks up the newest bypass value, ex beating wb.
    function automatic logic [31:0] resolve(input logic [4:0] tag, input logic [31:0] fallback);
        if (tag == 5'd0) return fallback;
        if (bus.exFwdValid && bus.exFwdRd == tag) return bus.exFwdData;
        if (bus.wbFwdValid && bus.wbFwdRd == tag) return bus.wbFwdData;
        return fallback;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit acc, drn;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            return;
        end
        acc = bus.inValid && (q.size() < 2);
        drn = bus.outReady && (q.size() > 0);
        if (drn) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) begin
            e    = q[i];
            e.d1 = resolve(e.t1, e.d1);
            e.d2 = resolve(e.t2, e.d2);
            q[i] = e;
        end
        if (acc) begin
            e.t1 = bus.inRs1;
            e.t2 = bus.inUseImm ? 5'd0 : bus.inRs2;
            e.d1 = resolve(e.t1, (bus.inRs1 == 5'd0) ? 32'd0 : rf_mem[bus.inRs1]);
            e.d2 = bus.inUseImm ? bus.inImm
                 : resolve(e.t2, (bus.inRs2 == 5'd0) ? 32'd0 : rf_mem[bus.inRs2]);
            e.op = bus.inOp;
            e.rd = bus.inRd;
            q.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        check_val("in_ready", bus.inReady, (q.size() < 2));
        check_val("out_valid", bus.outValid, (q.size() > 0));
        if (q.size() > 0) begin
            check_val("alu_in1", bus.aluIn1, q[0].d1);
            check_val("alu_in2", bus.aluIn2, q[0].d2);
            check_val("alu_op", bus.aluOp, q[0].op);
            check_val("out_rd", bus.outRd, q[0].rd);
        end
        check_val("rf_raddr1", bus.rfRaddr1, bus.inRs1);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive_instr(input logic v, input logic op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] imm, input logic use_imm);
        bus.inValid  = v;
        bus.inOp     = op;
        bus.inRs1    = rs1;
        bus.inRs2    = rs2;
        bus.inRd     = rd;
        bus.inImm    = imm;
        bus.inUseImm = use_imm;
    endtask

    task automatic bypass_off();
        bus.exFwdValid = 1'b0;
        bus.wbFwdValid = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_instr(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        bus.outReady = 1'b1;
        bypass_off();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rst_n = 1'b0;
        drive_instr(1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 32'h77, 1'b0);
        bus.outReady  = 1'b0;
        bus.exFwdValid = 1'b0; bus.exFwdRd = 5'd0; bus.exFwdData = 32'd0;
        bus.wbFwdValid = 1'b0; bus.wbFwdRd = 5'd0; bus.wbFwdData = 32'd0;
        @(negedge clk);
        tick();
        check_val("rst_out_valid", bus.outValid, 1'b0);
        check_val("rst_in_ready", bus.inReady, 1'b1);
        check_val("rst_alu_in1", bus.aluIn1, 32'd0);
        check_val("rst_alu_in2", bus.aluIn2, 32'd0);
        check_val("rst_alu_op", bus.aluOp, 1'b0);
        check_val("rst_out_rd", bus.outRd, 5'd0);
        rst_n = 1'b1;

        // Basic add from the register file
        rf_mem[1] = 32'd5; rf_mem[2] = 32'd7;
        bus.outReady = 1'b1;
        drive_instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0);
        tick();
        check_val("basic_valid", bus.outValid, 1'b1);
        check_val("basic_in1", bus.aluIn1, 32'd5);
        check_val("basic_in2", bus.aluIn2, 32'd7);
        check_val("basic_op", bus.aluOp, 1'b0);
        check_val("basic_ready", bus.inReady, 1'b1);

        // Bypass priority
        rf_mem[3] = 32'h30;
        bus.exFwdValid = 1'b1; bus.exFwdRd = 5'd3; bus.exFwdData = 32'h10;
        bus.wbFwdValid = 1'b1; bus.wbFwdRd = 5'd3; bus.wbFwdData = 32'h20;
        drive_instr(1'b1, 1'b1, 5'd3, 5'd0, 5'd10, 32'd0, 1'b0);
        tick();
        check_val("prio_ex", bus.aluIn1, 32'h10);
        bus.exFwdValid = 1'b0;
        tick();
        check_val("prio_wb", bus.aluIn1, 32'h20);
        bus.wbFwdValid = 1'b0;
        tick();
        check_val("prio_rf", bus.aluIn1, 32'h30);
        idle(2);

        // Skid buffer ordering
        bus.outReady = 1'b0;
        drive_instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd11, 32'd0, 1'b0);
        tick();
        drive_instr(1'b1, 1'b1, 5'd2, 5'd1, 5'd12, 32'd0, 1'b0);
        tick();
        check_val("skid_ready_low", bus.inReady, 1'b0);
        drive_instr(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        tick();
        check_val("skid_hold_rd", bus.outRd, 5'd11);
        bus.outReady = 1'b1;
        tick();
        check_val("skid_second_rd", bus.outRd, 5'd12);
        check_val("skid_ready_back", bus.inReady, 1'b1);
        tick();
        check_val("skid_empty", bus.outValid, 1'b0);

        // Snoop while stalled
        rf_mem[4] = 32'd1;
        bus.outReady = 1'b0;
        drive_instr(1'b1, 1'b0, 5'd4, 5'd2, 5'd13, 32'd0, 1'b0);
        tick();
        drive_instr(1'b1, 1'b0, 5'd4, 5'd2, 5'd14, 32'd0, 1'b0);
        tick();
        drive_instr(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        bus.wbFwdValid = 1'b1; bus.wbFwdRd = 5'd4; bus.wbFwdData = 32'hABCD;
        tick();
        bus.wbFwdValid = 1'b0;
        rf_mem[4] = 32'h5555;
        bus.outReady = 1'b1;
        check_val("snoop_o", bus.aluIn1, 32'hABCD);
        tick();
        check_val("snoop_s", bus.aluIn1, 32'hABCD);
        idle(1);

        // r0 never forwarded, immediate wins over bypass
        rf_mem[0] = 32'hDEAD;
        bus.exFwdValid = 1'b1; bus.exFwdRd = 5'd0; bus.exFwdData = 32'hFF;
        bus.wbFwdValid = 1'b1; bus.wbFwdRd = 5'd6; bus.wbFwdData = 32'h66;
        drive_instr(1'b1, 1'b1, 5'd0, 5'd6, 5'd15, 32'h1234, 1'b1);
        tick();
        check_val("r0_zero", bus.aluIn1, 32'd0);
        check_val("imm_wins", bus.aluIn2, 32'h1234);
        idle(2);

        // Reset while both slots are full
        bus.outReady = 1'b0;
        drive_instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd16, 32'd0, 1'b0);
        tick();
        drive_instr(1'b1, 1'b0, 5'd2, 5'd1, 5'd17, 32'd0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        check_val("mid_rst_valid", bus.outValid, 1'b0);
        check_val("mid_rst_ready", bus.inReady, 1'b1);
        rst_n = 1'b1;
        bus.outReady = 1'b1;
        rf_mem[7] = 32'h4242;
        drive_instr(1'b1, 1'b1, 5'd7, 5'd0, 5'd18, 32'd0, 1'b0);
        tick();
        check_val("post_rst_in1", bus.aluIn1, 32'h4242);
        check_val("post_rst_rd", bus.outRd, 5'd18);
        idle(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive_instr($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom), $urandom,
                        $urandom_range(0, 3) == 0);
            bus.outReady   = ($urandom_range(0, 2) != 0);
            bus.exFwdValid = 1'($urandom);
            bus.exFwdRd    = 5'($urandom_range(0, 7));
            bus.exFwdData  = $urandom;
            bus.wbFwdValid = 1'($urandom);
            bus.wbFwdRd    = 5'($urandom_range(0, 7));
            bus.wbFwdData  = $urandom;
            if ($urandom_range(0, 7) == 0) rf_mem[$urandom_range(0, 7)] = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
